// File: rtl/sbox_v2.sv
// sbox_v2 -- AES SubBytes via composite-field GF((2^4)^2) inversion.
// y is the same-cycle combinational result; y_q/out_valid are a one-cycle
// registered copy for pipelined round logic.
// Optional macro SBOX_INV_EN adds the inverse S-box (inv=1), sharing the
// GF(16) inversion core; without it, inv is ignored and y is always forward.
module sbox_v2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic       in_valid,
  input  logic       inv,
  output logic [7:0] y,
  output logic [7:0] y_q,
  output logic       out_valid
);

  // GF(16) multiply, field polynomial x^4+x+1 (shift-left, fold carry as 0x3).
  // NOTE: function and always_comb temporaries use blocking '=' (values are
  // needed immediately in the same evaluation); flops below use '<='.
  function automatic logic [3:0] gf_mul(input logic [3:0] p, input logic [3:0] q);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'h0;
    sh  = p;
    for (int k = 0; k < 4; k++) begin
      if (q[k]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  // GF(16) inverse as x^14; maps 0 to 0 naturally.
  function automatic logic [3:0] gf_inv(input logic [3:0] x);
    logic [3:0] x2, x4, x8;
    x2 = gf_mul(x, x);
    x4 = gf_mul(x2, x2);
    x8 = gf_mul(x4, x4);
    return gf_mul(gf_mul(x8, x4), x2);
  endfunction

  // Map a GF(2^8) byte into the composite-field representation.
  function automatic logic [7:0] iso(input logic [7:0] v);
    logic [7:0] r;
    r[7] = v[5]^v[7];
    r[6] = v[1]^v[4]^v[5]^v[6];
    r[5] = v[2]^v[3]^v[5]^v[7];
    r[4] = v[2]^v[3]^v[4]^v[6]^v[7];
    r[3] = v[1]^v[2]^v[6]^v[7];
    r[2] = v[2]^v[3]^v[6]^v[7];
    r[1] = v[1]^v[4]^v[6];
    r[0] = v[0]^v[1]^v[2]^v[3]^v[7];
    return r;
  endfunction

  // Composite-field multiplicative inverse (0 stays 0).
  function automatic logic [7:0] core_inv(input logic [7:0] i);
    logic [3:0] g1, g0, t, inv4;
    g1   = i[7:4];
    g0   = i[3:0];
    t    = gf_mul(g1, g0) ^ gf_mul(g0, g0) ^ gf_mul(gf_mul(g1, g1), 4'hD);
    inv4 = gf_inv(t);
    return {gf_mul(g1, inv4), gf_mul(g1 ^ g0, inv4)};
  endfunction

  // Inverse isomorphism fused with the forward affine transform.
  function automatic logic [7:0] fwd_out(input logic [7:0] d);
    logic [7:0] r;
    r[7] = d[1]^d[2]^d[3]^d[7];
    r[6] = ~(d[4]^d[7]);
    r[5] = ~(d[1]^d[2]^d[7]);
    r[4] = d[0]^d[1]^d[2]^d[4]^d[6]^d[7];
    r[3] = d[0];
    r[2] = d[0]^d[1]^d[3]^d[4];
    r[1] = ~(d[0]^d[2]^d[7]);
    r[0] = ~(d[0]^d[5]^d[6]^d[7]);
    return r;
  endfunction

`ifdef SBOX_INV_EN
  // Plain inverse isomorphism (no affine step), used by the inverse S-box.
  function automatic logic [7:0] inv_iso(input logic [7:0] d);
    logic [7:0] r;
    r[7] = d[1]^d[6]^d[7];
    r[6] = d[1]^d[2]^d[5]^d[6];
    r[5] = d[1]^d[6];
    r[4] = d[2]^d[4];
    r[3] = d[2]^d[3]^d[4]^d[5]^d[6];
    r[2] = d[2]^d[3]^d[4]^d[6]^d[7];
    r[1] = d[4]^d[5]^d[6];
    r[0] = d[0]^d[1]^d[4];
    return r;
  endfunction

  // Inverse affine transform: b'_i = b_(i+2) ^ b_(i+5) ^ b_(i+7) ^ 0x05_i.
  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++)
      r[k] = b[(k+2)%8] ^ b[(k+5)%8] ^ b[(k+7)%8];
    return r ^ 8'h05;
  endfunction

  // Shared inversion core; only the pre/post linear maps depend on inv.
  always_comb begin
    logic [7:0] core_in;
    logic [7:0] core_out;
    core_in  = iso(inv ? inv_affine(a) : a);
    core_out = core_inv(core_in);
    y        = inv ? inv_iso(core_out) : fwd_out(core_out);
  end
`else
  // inv is intentionally not consumed, so an unknown inv cannot reach y.
  logic unused_inv;
  assign unused_inv = inv;

  // Forward S-box only.
  always_comb begin
    y = fwd_out(core_inv(iso(a)));
  end
`endif

  // Registered copy: capture y only on valid beats, valid flag follows in_valid.
  // NOTE: both flops are on the async reset; y_q is a plain 8-bit register,
  // not a memory, so clearing it costs nothing and avoids stale data after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) y_q <= y;
    end
  end

endmodule

// File: tb/tb_sbox_v2.sv
// tb_sbox_v2 -- directed checks of sbox_v2 against the FIPS-197 table.
// Inverse-mode checks are built only when SBOX_INV_EN is defined.
module tb_sbox_v2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a;
  logic       in_valid;
  logic       inv;
  logic [7:0] y;
  logic [7:0] y_q;
  logic       out_valid;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [0:255][7:0] SBOX = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  sbox_v2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .in_valid  (in_valid),
    .inv       (inv),
    .y         (y),
    .y_q       (y_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  // Drive a shortly after the rising edge, then check y at the falling edge.
  task automatic comb_check(input string tag, input logic [7:0] din,
                            input logic mode, input logic [7:0] exp);
    @(posedge clk);
    #1;
    a   = din;
    inv = mode;
    @(negedge clk);
    check(tag, y, exp);
  endtask

  initial begin
    logic [7:0] sv;
    rst_n    = 1'b0;
    a        = 8'h00;
    in_valid = 1'b0;
    inv      = 1'b0;
    #12;
    check("rst_y_q", y_q, 8'h00);
    check("rst_out_valid", {7'd0, out_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Spot values and exhaustive forward sweep.
    comb_check("spot_00", 8'h00, 1'b0, 8'h63);
    comb_check("spot_01", 8'h01, 1'b0, 8'h7c);
    comb_check("spot_53", 8'h53, 1'b0, 8'hed);
    comb_check("spot_10", 8'h10, 1'b0, 8'hca);
    comb_check("spot_ff", 8'hff, 1'b0, 8'h16);
    for (int i = 0; i < 256; i++) begin
      sv = SBOX[i];
      comb_check($sformatf("fwd_%02h", i), i[7:0], 1'b0, sv);
    end

    // Registered path: capture, then hold while in_valid is low.
    @(posedge clk);
    #1;
    a = 8'h53; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("reg_y_q_cap", y_q, 8'hed);
    check("reg_out_valid_hi", {7'd0, out_valid}, 8'h01);
    a = 8'h00; in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("reg_y_q_hold", y_q, 8'hed);
    check("reg_out_valid_lo", {7'd0, out_valid}, 8'h00);

    // Asynchronous reset between edges clears immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_y_q", y_q, 8'h00);
    check("arst_out_valid", {7'd0, out_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    a = 8'h53;
    @(posedge clk);
    #1;
    check("post_rst_y_q", y_q, 8'h00);
    check("post_rst_out_valid", {7'd0, out_valid}, 8'h00);

    // Back-to-back valid beats.
    a = 8'h01; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_01", y_q, 8'h7c);
    check("b2b_v1", {7'd0, out_valid}, 8'h01);
    a = 8'h02;
    @(posedge clk);
    #1;
    check("b2b_02", y_q, 8'h77);
    a = 8'h03;
    @(posedge clk);
    #1;
    check("b2b_03", y_q, 8'h7b);
    in_valid = 1'b0;

`ifdef SBOX_INV_EN
    comb_check("inv_63", 8'h63, 1'b1, 8'h00);
    comb_check("inv_ed", 8'hed, 1'b1, 8'h53);
    comb_check("inv_16", 8'h16, 1'b1, 8'hff);
    for (int i = 0; i < 256; i++) begin
      sv = SBOX[i];
      comb_check($sformatf("rt_%02h", i), sv, 1'b1, i[7:0]);
    end
    comb_check("fwd_after_inv_53", 8'h53, 1'b0, 8'hed);
`else
    comb_check("noinv_53_inv1", 8'h53, 1'b1, 8'hed);
    comb_check("noinv_53_inv0", 8'h53, 1'b0, 8'hed);
    comb_check("noinv_63_inv1", 8'h63, 1'b1, 8'hfb);
    comb_check("noinv_00_invx", 8'h00, 1'bx, 8'h63);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
